// File: rtl/ccr_branch_resolver.sv
// Condition-code register, jump resolver, PC redirect / flush sequencer and CCR save stack.
// Optional macro FLAG_FWD_EN: branches see this cycle's masked ALU flag write.
module ccr_branch_resolver #(
    parameter int FLUSH_CYCLES = 2,
    parameter int SAVE_DEPTH   = 2,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              alu_flags_vld,
    input  logic [2:0]        alu_flags,
    input  logic [2:0]        alu_flag_mask,
    input  logic              br_vld,
    input  logic [1:0]        br_type,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic [2:0]        ccr,
    output logic              br_taken,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              flush,
    output logic              stack_err
);

    localparam int              SP_W     = $clog2(SAVE_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_ONE   = 1;
    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(SAVE_DEPTH);
    localparam logic [2:0]      CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_e;
    typedef enum logic [1:0] {BR_JZ = 2'b00, BR_JN = 2'b01, BR_JC = 2'b10, BR_JMP = 2'b11} br_type_e;

    state_e          state;
    logic [2:0]      cnt;
    logic [SP_W-1:0] sp;
    // Sized to a power of two so the pointer indexes it without width games.
    logic [2:0]      stack_mem [2**SP_W];

    logic [2:0] wr_en, ccr_alu, ccr_eval, clr_mask, ccr_base, ccr_next;
    logic       cond, take;
    logic       stack_empty, stack_full, do_pop, do_push, stack_fault;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cond     = 1'b0;
        clr_mask = 3'b000;
        wr_en    = alu_flag_mask & {3{alu_flags_vld}};
        ccr_alu  = (alu_flags & wr_en) | (ccr & ~wr_en);
`ifdef FLAG_FWD_EN
        ccr_eval = ccr_alu;
`else
        ccr_eval = ccr;
`endif
        case (br_type_e'(br_type))
            BR_JZ:   begin cond = ccr_eval[0]; clr_mask = 3'b001; end
            BR_JN:   begin cond = ccr_eval[1]; clr_mask = 3'b010; end
            BR_JC:   begin cond = ccr_eval[2]; clr_mask = 3'b100; end
            BR_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
        take     = (state == S_IDLE) && br_vld && cond;
        ccr_base = ccr_alu & ~(take ? clr_mask : 3'b000);

        stack_empty = (sp == '0);
        stack_full  = (sp == SP_FULL);
        do_pop      = rti_restore && !stack_empty;
        // A simultaneous save and restore performs only the pop.
        do_push     = int_save && !rti_restore && !stack_full;
        stack_fault = (rti_restore && stack_empty) || (int_save && (rti_restore || stack_full));
        ccr_next    = do_pop ? stack_mem[sp - SP_ONE] : ccr_base;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sp          <= '0;
            ccr         <= 3'b000;
            br_taken    <= 1'b0;
            pc_redirect <= '0;
            flush       <= 1'b0;
            stack_err   <= 1'b0;
        end else if (!stall) begin
            ccr <= ccr_next;
            if (stack_fault) stack_err <= 1'b1;
            if (do_push)     sp <= sp + SP_ONE;
            else if (do_pop) sp <= sp - SP_ONE;

            case (state)
                S_IDLE: begin
                    br_taken <= take;
                    if (take) begin
                        pc_redirect <= br_target;
                        flush       <= 1'b1;
                        cnt         <= CNT_LOAD;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    br_taken <= 1'b0;
                    if (cnt == 3'd0) begin
                        flush <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: stack storage is not reset; the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!stall && do_push) stack_mem[sp] <= ccr_base;
    end

endmodule

// File: tb/tb_ccr_branch_resolver.sv
// Directed self-checking bench for ccr_branch_resolver (default parameters).
// Honours FLAG_FWD_EN when defined at compile time.
module tb_ccr_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        alu_flags_vld;
    logic [2:0]  alu_flags;
    logic [2:0]  alu_flag_mask;
    logic        br_vld;
    logic [1:0]  br_type;
    logic [15:0] br_target;
    logic        int_save;
    logic        rti_restore;
    logic [2:0]  ccr;
    logic        br_taken;
    logic [15:0] pc_redirect;
    logic        flush;
    logic        stack_err;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_ccr_t4;
    logic       exp_take_t4;

    ccr_branch_resolver #(.FLUSH_CYCLES(2), .SAVE_DEPTH(2), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .alu_flags_vld(alu_flags_vld), .alu_flags(alu_flags), .alu_flag_mask(alu_flag_mask),
        .br_vld(br_vld), .br_type(br_type), .br_target(br_target),
        .int_save(int_save), .rti_restore(rti_restore),
        .ccr(ccr), .br_taken(br_taken), .pc_redirect(pc_redirect),
        .flush(flush), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] f, input logic [2:0] m);
        alu_flags_vld = 1'b1;
        alu_flags     = f;
        alu_flag_mask = m;
    endtask

    task automatic idle();
        alu_flags_vld = 1'b0;
        br_vld        = 1'b0;
        int_save      = 1'b0;
        rti_restore   = 1'b0;
    endtask

    task automatic branch(input logic [1:0] t, input logic [15:0] tgt);
        br_vld    = 1'b1;
        br_type   = t;
        br_target = tgt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        alu_flags = 3'b000; alu_flag_mask = 3'b000; br_type = 2'b00; br_target = 16'h0;
        idle();
`ifdef FLAG_FWD_EN
        exp_ccr_t4 = 3'b000; exp_take_t4 = 1'b1;
`else
        exp_ccr_t4 = 3'b001; exp_take_t4 = 1'b0;
`endif
        #12;
        check("rst_ccr", ccr, 3'b000);
        check("rst_taken", br_taken, 1'b0);
        check("rst_pc", pc_redirect, 16'h0);
        check("rst_flush", flush, 1'b0);
        check("rst_err", stack_err, 1'b0);
        rst_n = 1'b1;
        step();

        // Taken JZ clears Z and flushes for two cycles
        alu(3'b001, 3'b111); step(); idle();
        check("t2_ccr_set", ccr, 3'b001);
        branch(2'b00, 16'h0040); step(); idle();
        check("t2_taken", br_taken, 1'b1);
        check("t2_pc", pc_redirect, 16'h0040);
        check("t2_ccr_clr", ccr, 3'b000);
        check("t2_flush0", flush, 1'b1);
        step();
        check("t2_pulse", br_taken, 1'b0);
        check("t2_flush1", flush, 1'b1);
        step();
        check("t2_flush_end", flush, 1'b0);

        // Not-taken JN, then JMP with a wrong-path JMP ignored
        branch(2'b01, 16'h0100); step(); idle();
        check("t3_jn_taken", br_taken, 1'b0);
        check("t3_jn_flush", flush, 1'b0);
        branch(2'b11, 16'h1234); step();
        check("t3_jmp_taken", br_taken, 1'b1);
        check("t3_jmp_pc", pc_redirect, 16'h1234);
        check("t3_jmp_flush", flush, 1'b1);
        branch(2'b11, 16'h5678); step(); idle();
        check("t3_ign_taken", br_taken, 1'b0);
        check("t3_ign_pc", pc_redirect, 16'h1234);
        check("t3_ign_flush", flush, 1'b1);
        step();
        check("t3_end_flush", flush, 1'b0);
        check("t3_end_taken", br_taken, 1'b0);

        // Masked ALU writes and a taken JC clearing only C
        alu(3'b011, 3'b111); step(); idle();
        check("mask_full", ccr, 3'b011);
        alu(3'b100, 3'b100); step(); idle();
        check("mask_c", ccr, 3'b111);
        alu(3'b000, 3'b010); step(); idle();
        check("mask_n", ccr, 3'b101);
        branch(2'b10, 16'h0200); step(); idle();
        check("jc_taken", br_taken, 1'b1);
        check("jc_ccr", ccr, 3'b001);
        step(); step();
        check("jc_flush_end", flush, 1'b0);

        // ALU write of Z in the same cycle as JZ
        alu(3'b000, 3'b111); step(); idle();
        alu(3'b001, 3'b001); branch(2'b00, 16'h0080); step(); idle();
        check("t4_taken", br_taken, exp_take_t4);
        check("t4_ccr", ccr, exp_ccr_t4);
        step(); step();
        check("t4_flush_end", flush, 1'b0);

        // Stall during flush freezes flush, pulse and CCR
        branch(2'b11, 16'h0abc); step(); idle();
        check("t6_taken", br_taken, 1'b1);
        check("t6_flush", flush, 1'b1);
        stall = 1'b1;
        alu(3'b010, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stall_flush", flush, 1'b1);
            check("t6_stall_taken", br_taken, 1'b1);
            check("t6_stall_ccr", ccr, exp_ccr_t4);
        end
        stall = 1'b0; idle();
        step();
        check("t6_post_taken", br_taken, 1'b0);
        check("t6_post_flush", flush, 1'b1);
        step();
        check("t6_flush_end", flush, 1'b0);

        // Asynchronous reset in the middle of a flush
        alu(3'b111, 3'b111); step(); idle();
        check("t1_ccr_pre", ccr, 3'b111);
        branch(2'b11, 16'h0300); step(); idle();
        check("t1_flush_pre", flush, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_flush", flush, 1'b0);
        check("t1_taken", br_taken, 1'b0);
        check("t1_ccr", ccr, 3'b000);
        check("t1_pc", pc_redirect, 16'h0);
        #1 rst_n = 1'b1;
        step();

        // Flag stack: overflow, pop priority over ALU, underflow keeps CCR
        alu(3'b100, 3'b111); int_save = 1'b1; step(); idle();
        alu(3'b010, 3'b111); int_save = 1'b1; step(); idle();
        check("t5_ccr_010", ccr, 3'b010);
        check("t5_err0", stack_err, 1'b0);
        int_save = 1'b1; step(); idle();
        check("t5_ovf_err", stack_err, 1'b1);
        check("t5_ovf_ccr", ccr, 3'b010);
        alu(3'b111, 3'b111); step(); idle();
        check("t5_ccr_111", ccr, 3'b111);
        alu(3'b111, 3'b111); rti_restore = 1'b1; step(); idle();
        check("t5_pop1", ccr, 3'b010);
        rti_restore = 1'b1; step(); idle();
        check("t5_pop2", ccr, 3'b100);
        rti_restore = 1'b1; step(); idle();
        check("t5_pop3", ccr, 3'b100);
        check("t5_err_sticky", stack_err, 1'b1);

        // Underflow with an ALU write follows the ALU value
        do_reset();
        check("uf_err_clr", stack_err, 1'b0);
        alu(3'b011, 3'b111); rti_restore = 1'b1; step(); idle();
        check("uf_ccr", ccr, 3'b011);
        check("uf_err", stack_err, 1'b1);

        // Save and restore together: pop wins, push dropped
        do_reset();
        alu(3'b110, 3'b111); int_save = 1'b1; step(); idle();
        alu(3'b001, 3'b111); step(); idle();
        check("sr_ccr", ccr, 3'b001);
        check("sr_err0", stack_err, 1'b0);
        int_save = 1'b1; rti_restore = 1'b1; step(); idle();
        check("sr_pop", ccr, 3'b110);
        check("sr_err", stack_err, 1'b1);
        rti_restore = 1'b1; step(); idle();
        check("sr_empty", ccr, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
